// File: rtl/serial_subtractor32_pkg.sv
// Shared types and default sizing for the slice-serial subtractor.
package serial_subtractor32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 32;
    localparam int SLICE_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor32_sub_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor built from per-bit full subtractors.
module sub_slice #(
    parameter int SLICE = 8
) (
    output logic             bout,
    output logic [SLICE-1:0] d,
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             bin
);

    logic [SLICE:0] chain;

    assign chain[0] = bin;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            assign d[gi]        = x[gi] ^ y[gi] ^ chain[gi];
            assign chain[gi+1]  = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & chain[gi]);
        end
    endgenerate

    assign bout = chain[SLICE];

endmodule

// File: rtl/serial_subtractor32.sv
// Slice-serial subtractor: one SLICE-bit chunk per clock, LSB first, borrow carried in a register.
module serial_subtractor32
    import serial_subtractor32_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEFAULT,
    parameter int SLICE  = SLICE_DEFAULT,
    parameter int NSLICE = WIDTH / SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int IDXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              borrow_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [WIDTH-1:0]  diff_reg;
    logic              borrow_out_reg;
    logic              overflow_reg;
    logic              zero_reg;
    logic              in_ready_reg;
    logic              out_valid_reg;

    logic [SLICE-1:0]  a_slices [NSLICE];
    logic [SLICE-1:0]  b_slices [NSLICE];
    logic [SLICE-1:0]  slice_d;
    logic              slice_bout;
    logic [WIDTH-1:0]  diff_next;

    // Single slice datapath, steered by idx_reg; diff_next splices its result into place.
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_slices[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_slices[gi] = b_reg[gi*SLICE +: SLICE];
            assign diff_next[gi*SLICE +: SLICE] =
                (idx_reg == IDXW'(gi)) ? slice_d : diff_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    sub_slice #(.SLICE(SLICE)) u_slice (
        .bout (slice_bout),
        .d    (slice_d),
        .x    (a_slices[idx_reg]),
        .y    (b_slices[idx_reg]),
        .bin  (borrow_reg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            borrow_reg     <= 1'b0;
            idx_reg        <= '0;
            diff_reg       <= '0;
            borrow_out_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            zero_reg       <= 1'b0;
            in_ready_reg   <= 1'b1;
            out_valid_reg  <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a;
                        b_reg        <= b;
                        borrow_reg   <= borrow_in;
                        diff_reg     <= '0;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    diff_reg   <= diff_next;
                    borrow_reg <= slice_bout;
                    idx_reg    <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        borrow_out_reg <= slice_bout;
                        overflow_reg   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                                          (diff_next[WIDTH-1] != a_reg[WIDTH-1]);
                        zero_reg       <= (diff_next == '0);
                        out_valid_reg  <= 1'b1;
                        state_reg      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = out_valid_reg;
    assign diff       = diff_reg;
    assign borrow_out = borrow_out_reg;
    assign overflow   = overflow_reg;
    assign zero       = zero_reg;

endmodule
